// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic light controller input front-end.
// Field geometry, commit FSM states and the zero-field clamp.
package traffic_pkg;

    localparam int FIELD_W    = 4;
    localparam int NUM_FIELDS = 3;
    localparam int CFG_W      = FIELD_W * NUM_FIELDS;
    localparam logic [FIELD_W-1:0] MIN_FIELD = 4'd1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COMMIT
    } commit_state_e;

    // A zero field would stall the controller, so it is raised to the minimum.
    function automatic logic [CFG_W-1:0] clamp_cfg(input logic [CFG_W-1:0] raw);
        logic [CFG_W-1:0] res;
        res = raw;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (raw[f*FIELD_W +: FIELD_W] == '0) begin
                res[f*FIELD_W +: FIELD_W] = MIN_FIELD;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchroniser followed by a counting debouncer for one board input.
// The stable value flips only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_cell #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic stable_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= RST_VAL;
            sync2_q  <= RST_VAL;
            stable_q <= RST_VAL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any return to the stable value restarts the count, discarding short bounces.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/traffic_input_conditioner.sv
// Debounces the board switches/button and commits clamped switch config after it settles.
// Optional CFG_LOCK_EN: while the mode switch is on, config commits are held off.
module traffic_input_conditioner
    import traffic_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               SETTLE_CYCLES   = 8,
    parameter logic [CFG_W-1:0] RESET_CFG       = 12'hFF2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CFG_W-1:0] sw_raw,
    input  logic             sw_mode_raw,
    input  logic             btn_ctrl_raw,
    output logic [CFG_W-1:0] sw_led,
    output logic             controll_led,
    output logic             sw_mode,
    output logic             cfg_update
);

    localparam int NUM_IN = CFG_W + 2;
    localparam logic [NUM_IN-1:0] RST_VALS = {2'b00, RESET_CFG};
    localparam int SCW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SCNT_MAX = SCW'(SETTLE_CYCLES - 1);

    logic [NUM_IN-1:0] raw_all, stable_all;
    logic [CFG_W-1:0]  cfg_next;
    logic              mode_stable, btn_stable;

    assign raw_all = {btn_ctrl_raw, sw_mode_raw, sw_raw};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RST_VAL        (RST_VALS[i])
        ) u_cell (
            .clk_i   (clk),
            .rst_ni  (rst),
            .raw_i   (raw_all[i]),
            .stable_o(stable_all[i])
        );
    end

    assign cfg_next    = clamp_cfg(stable_all[CFG_W-1:0]);
    assign mode_stable = stable_all[CFG_W];
    assign btn_stable  = stable_all[CFG_W+1];

    commit_state_e    state_q, state_d;
    logic [SCW-1:0]   cnt_q, cnt_d;
    logic [CFG_W-1:0] cfg_prev_q, sw_led_q;
    logic             cfg_update_q, commit_en;
    logic             btn_prev_q, ctrl_led_q, ctrl_led_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cfg_prev_q <= clamp_cfg(RESET_CFG);
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cfg_prev_q <= cfg_next;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cfg_next != sw_led_q) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cfg_next == sw_led_q) begin
                    state_d = IDLE;
                end else if (cfg_next != cfg_prev_q) begin
                    cnt_d = '0;
                end else if (cnt_q == SCNT_MAX) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef CFG_LOCK_EN
        if (mode_stable) begin
            state_d = IDLE;
        end
`endif
    end

    always_comb begin
        commit_en = (state_q == COMMIT);
    end

    assign ctrl_led_d = ctrl_led_q ^ (btn_stable & ~btn_prev_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_led_q     <= RESET_CFG;
            cfg_update_q <= 1'b0;
            btn_prev_q   <= 1'b0;
            ctrl_led_q   <= 1'b0;
        end else begin
            if (commit_en) begin
                sw_led_q <= cfg_next;
            end
            cfg_update_q <= commit_en;
            btn_prev_q   <= btn_stable;
            ctrl_led_q   <= ctrl_led_d;
        end
    end

    assign sw_led       = sw_led_q;
    assign cfg_update   = cfg_update_q;
    assign controll_led = ctrl_led_q;
    assign sw_mode      = mode_stable;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed bench for traffic_input_conditioner with a window-based reference model.
// Build with CFG_LOCK_EN defined to also exercise the config lock.
module tb_traffic_input_conditioner;

    localparam logic [11:0] RESET_CFG = 12'hFF2;
    localparam logic [13:0] RV = {2'b00, RESET_CFG};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] sw_raw = RESET_CFG;
    logic        sw_mode_raw = 1'b0;
    logic        btn_ctrl_raw = 1'b0;
    logic [11:0] sw_led;
    logic        controll_led, sw_mode, cfg_update;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit chk_en = 1'b0;

    traffic_input_conditioner #(
        .DEBOUNCE_CYCLES(16),
        .SETTLE_CYCLES  (8),
        .RESET_CFG      (RESET_CFG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_raw      (sw_raw),
        .sw_mode_raw (sw_mode_raw),
        .btn_ctrl_raw(btn_ctrl_raw),
        .sw_led      (sw_led),
        .controll_led(controll_led),
        .sw_mode     (sw_mode),
        .cfg_update  (cfg_update)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] clampm(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int f = 0; f < 3; f++)
            if (v[f*4 +: 4] == 4'd0) r[f*4 +: 4] = 4'd1;
        return r;
    endfunction

    // Reference model: an input's stable value flips once the raw samples seen two
    // edges late have all opposed it for 16 edges; a commit lands on the edge after
    // nine consecutive edges of identical clamped config that differs from sw_led.
    logic [13:0] rawh[$];
    logic [11:0] ch[$];
`ifdef CFG_LOCK_EN
    logic        mh[$];
`endif
    logic [13:0] mst, nst;
    logic [11:0] m_led, cpre;
    logic        m_cl, m_upd, m_btn_prev, commit, all_diff;
    int          n;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            rawh.delete();
            repeat (20) rawh.push_back(RV);
            ch.delete();
`ifdef CFG_LOCK_EN
            mh.delete();
`endif
            mst = RV; m_led = RESET_CFG; m_cl = 1'b0; m_upd = 1'b0; m_btn_prev = 1'b0;
        end else begin
            cpre = clampm(mst[11:0]);
            if (mst[13] && !m_btn_prev) m_cl = !m_cl;
            m_btn_prev = mst[13];
            n = ch.size();
            commit = (n >= 9);
            if (commit) begin
                for (int k = 1; k <= 9; k++) begin
                    if (ch[n-k] !== ch[n-1] || ch[n-k] == m_led) commit = 1'b0;
`ifdef CFG_LOCK_EN
                    if (mh[n-k]) commit = 1'b0;
`endif
                end
            end
            m_upd = commit;
            if (commit) m_led = cpre;
            ch.push_back(cpre);
            if (ch.size() > 12) void'(ch.pop_front());
`ifdef CFG_LOCK_EN
            mh.push_back(mst[12]);
            if (mh.size() > 12) void'(mh.pop_front());
`endif
            rawh.push_back({btn_ctrl_raw, sw_mode_raw, sw_raw});
            nst = mst;
            for (int i = 0; i < 14; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < 16; k++)
                    if (rawh[rawh.size()-3-k][i] == mst[i]) all_diff = 1'b0;
                if (all_diff) nst[i] = ~mst[i];
            end
            mst = nst;
            if (rawh.size() > 24) void'(rawh.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("sw_led",       32'(sw_led),       32'(m_led));
            check("controll_led", 32'(controll_led), 32'(m_cl));
            check("sw_mode",      32'(sw_mode),      32'(mst[12]));
            check("cfg_update",   32'(cfg_update),   32'(m_upd));
        end
    end

    initial forever begin
        @(posedge clk);
        if (rst && cfg_update) pulses++;
    end

    task automatic wait_cyc(input int c);
        repeat (c) @(negedge clk);
    endtask

    int p0, lat;

    initial begin
        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sw_led", 32'(sw_led), 32'h0FF2);
        check("rst_ctrl_led", 32'(controll_led), 32'd0);
        check("rst_sw_mode", 32'(sw_mode), 32'd0);
        check("rst_cfg_update", 32'(cfg_update), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        wait_cyc(40);
        check("t1_no_pulse", 32'(pulses), 32'd0);

        // 2: clean step, latency from the raw change to the pulse
        p0 = pulses; lat = 0;
        sw_raw = 12'h345;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (cfg_update && lat == 0) lat = k;
        end
        check("t2_latency", 32'(lat), 32'd28);
        check("t2_sw_led", 32'(sw_led), 32'h345);
        check("t2_pulses", 32'(pulses - p0), 32'd1);

        // 3: bouncing bit never commits
        @(negedge clk);
        p0 = pulses;
        for (int k = 0; k < 12; k++) begin
            sw_raw[0] = ~sw_raw[0];
            wait_cyc(5);
        end
        sw_raw = 12'h345;
        wait_cyc(40);
        check("t3_sw_led", 32'(sw_led), 32'h345);
        check("t3_pulses", 32'(pulses - p0), 32'd0);

        // 4: zero fields clamp to one
        p0 = pulses;
        sw_raw = 12'h0A0;
        wait_cyc(40);
        check("t4_sw_led", 32'(sw_led), 32'h1A1);
        check("t4_pulses", 32'(pulses - p0), 32'd1);

        // 5: button glitch ignored, long presses toggle once each
        btn_ctrl_raw = 1'b1; wait_cyc(3); btn_ctrl_raw = 1'b0;
        wait_cyc(30);
        check("t5_short", 32'(controll_led), 32'd0);
        btn_ctrl_raw = 1'b1; wait_cyc(40); btn_ctrl_raw = 1'b0;
        wait_cyc(30);
        check("t5_press1", 32'(controll_led), 32'd1);
        btn_ctrl_raw = 1'b1; wait_cyc(40); btn_ctrl_raw = 1'b0;
        wait_cyc(30);
        check("t5_press2", 32'(controll_led), 32'd0);

`ifdef CFG_LOCK_EN
        // 6: commits held while mode switch is on
        p0 = pulses;
        sw_mode_raw = 1'b1;
        wait_cyc(25);
        check("t6_mode_on", 32'(sw_mode), 32'd1);
        sw_raw = 12'h222;
        wait_cyc(60);
        check("t6_locked", 32'(sw_led), 32'h1A1);
        check("t6_locked_pulses", 32'(pulses - p0), 32'd0);
        sw_mode_raw = 1'b0;
        wait_cyc(40);
        check("t6_unlocked", 32'(sw_led), 32'h222);
        check("t6_pulses", 32'(pulses - p0), 32'd1);
`endif

        // 7: reset mid-settle drops the pending change
        btn_ctrl_raw = 1'b1; wait_cyc(40); btn_ctrl_raw = 1'b0;
        wait_cyc(25);
        check("t7_ctrl_pre", 32'(controll_led), 32'd1);
        p0 = pulses;
        sw_raw = 12'h777;
        repeat (22) @(posedge clk);
        #2;
        rst = 1'b0;
        sw_raw = RESET_CFG;
        #1;
        check("t7_sw_led", 32'(sw_led), 32'h0FF2);
        check("t7_ctrl_led", 32'(controll_led), 32'd0);
        check("t7_cfg_update", 32'(cfg_update), 32'd0);
        check("t7_sw_mode", 32'(sw_mode), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        wait_cyc(40);
        check("t7_after_sw_led", 32'(sw_led), 32'h0FF2);
        check("t7_pulses", 32'(pulses - p0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
